// File: rtl/amplitude_mixer_pwm.sv
// rtl/amplitude_mixer_pwm.sv - PSG output stage: per-channel gating, log-to-linear levels, three-channel mix and frame-synchronous PWM DAC
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   tone[2:0]      tone generator outputs (bit0 = A, bit1 = B, bit2 = C)
//   noise          shared noise generator output
//   tone_disable   per-channel mixer bits, 1 = tone ignored
//   noise_disable  per-channel mixer bits, 1 = noise ignored
//   amplitude_a/b/c  bit4 = envelope mode, bits[3:0] = fixed level
//   envelope       shared envelope generator output
//   mix_out        registered sum of the three linear levels
//   frame_start    one-clock pulse marking the first clock of each PWM output frame
//   pwm_out        registered PWM DAC bit

module amplitude_mixer_pwm #(
    parameter int ENVELOPE_BITS = 4,
    parameter int LEVEL_BITS    = 8,
    parameter int MIX_BITS      = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               tone,
    input  logic                     noise,
    input  logic [2:0]               tone_disable,
    input  logic [2:0]               noise_disable,
    input  logic [ENVELOPE_BITS:0]   amplitude_a,
    input  logic [ENVELOPE_BITS:0]   amplitude_b,
    input  logic [ENVELOPE_BITS:0]   amplitude_c,
    input  logic [ENVELOPE_BITS-1:0] envelope,
    output logic [MIX_BITS-1:0]      mix_out,
    output logic                     frame_start,
    output logic                     pwm_out
);

    // Roughly 3 dB per step; index 0 is true silence.
    localparam logic [7:0] LOG_TABLE [16] = '{
        8'd0,  8'd2,  8'd3,  8'd4,  8'd6,   8'd8,   8'd11,  8'd16,
        8'd23, 8'd32, 8'd45, 8'd64, 8'd90,  8'd128, 8'd181, 8'd255
    };

    logic [ENVELOPE_BITS:0]   amp     [3];
    logic                     chan_on [3];
    logic [ENVELOPE_BITS-1:0] level   [3];
    logic [LEVEL_BITS-1:0]    lin     [3];
    logic [MIX_BITS-1:0]      sum;

    logic [MIX_BITS-1:0]      counter;
    logic [MIX_BITS-1:0]      duty;

    assign amp[0] = amplitude_a;
    assign amp[1] = amplitude_b;
    assign amp[2] = amplitude_c;

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            // A disable bit forces its term high, so with both disables set
            // the channel is permanently on and its level passes as DC.
            chan_on[n] = (tone[n] | tone_disable[n]) & (noise | noise_disable[n]);
            if (!chan_on[n]) begin
                level[n] = '0;
            end else if (amp[n][ENVELOPE_BITS]) begin
                level[n] = envelope;
            end else begin
                level[n] = amp[n][ENVELOPE_BITS-1:0];
            end
            lin[n] = LEVEL_BITS'(LOG_TABLE[level[n]]);
        end
    end

    // Worst case 3 * 255 = 765 fits the mix width, so no saturation needed.
    assign sum = MIX_BITS'(lin[0]) + MIX_BITS'(lin[1]) + MIX_BITS'(lin[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mix_out     <= '0;
            counter     <= '0;
            duty        <= '0;
            frame_start <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            mix_out <= sum;
            counter <= counter + MIX_BITS'(1);

            // Registered from the counter like pwm_out, so the pulse lines up
            // with the pwm_out sample produced for counter == 0.
            frame_start <= (counter == '0);

            // Duty only changes across the wrap, so a frame in progress
            // always completes with the duty it started with.
            if (counter == '1) begin
                duty <= mix_out;
            end

            // Strict compare: duty tops out at 765, so never high a full frame.
            pwm_out <= (counter < duty);
        end
    end

endmodule

// File: tb/tb_amplitude_mixer_pwm.sv
// tb/tb_amplitude_mixer_pwm.sv - scoreboard testbench for amplitude_mixer_pwm

module tb_amplitude_mixer_pwm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] tone = '0;
    logic       noise = 1'b0;
    logic [2:0] tone_disable = '0;
    logic [2:0] noise_disable = '0;
    logic [4:0] amplitude_a = '0;
    logic [4:0] amplitude_b = '0;
    logic [4:0] amplitude_c = '0;
    logic [3:0] envelope = '0;
    logic [9:0] mix_out;
    logic       frame_start;
    logic       pwm_out;

    int errors = 0;
    int checks = 0;

    int mix_q   [$];
    int frame_q [$];

    int ref_table [16] = '{0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 181, 255};

    amplitude_mixer_pwm dut (
        .clk           (clk),
        .reset         (reset),
        .tone          (tone),
        .noise         (noise),
        .tone_disable  (tone_disable),
        .noise_disable (noise_disable),
        .amplitude_a   (amplitude_a),
        .amplitude_b   (amplitude_b),
        .amplitude_c   (amplitude_c),
        .envelope      (envelope),
        .mix_out       (mix_out),
        .frame_start   (frame_start),
        .pwm_out       (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int ref_channel(input int n, input logic [4:0] amp);
        logic gate;
        int   idx;
        gate = (tone[n] | tone_disable[n]) & (noise | noise_disable[n]);
        idx  = amp[4] ? int'(envelope) : int'(amp[3:0]);
        return gate ? ref_table[idx] : 0;
    endfunction

    function automatic int ref_mix();
        return ref_channel(0, amplitude_a) + ref_channel(1, amplitude_b) + ref_channel(2, amplitude_c);
    endfunction

    task automatic push_expect();
        mix_q.push_back(ref_mix());
    endtask

    // Advance one clock and sample away from the edge; any pending mix
    // expectation belongs to the inputs driven before this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mix_q.size() > 0) begin
            check_val("mix_out", int'(mix_out), mix_q.pop_front());
        end
    endtask

    // Entered on a frame_start cycle; leaves on the following frame_start cycle.
    task automatic measure_frame(input int change_at, input logic [4:0] new_amp_b);
        int highs;
        int starts;
        highs  = int'(pwm_out);
        starts = 0;
        for (int i = 1; i < 1024; i++) begin
            if (i == change_at) begin
                amplitude_b = new_amp_b;
                push_expect();
            end
            tick();
            highs  += int'(pwm_out);
            starts += int'(frame_start);
        end
        tick();
        check_val("frame_period", int'(frame_start), 1);
        check_val("frame_start_midframe", starts, 0);
        if (frame_q.size() > 0) begin
            check_val("pwm_high_count", highs, frame_q.pop_front());
        end
    endtask

    task automatic wait_frame_start();
        int n;
        n = 0;
        while (!frame_start && n < 1100) begin
            tick();
            n++;
        end
        if (!frame_start) begin
            check_val("frame_start_timeout", 0, 1);
        end
    endtask

    initial begin
        // Reset state.
        repeat (3) tick();
        check_val("reset_mix_out", int'(mix_out), 0);
        check_val("reset_pwm_out", int'(pwm_out), 0);
        check_val("reset_frame_start", int'(frame_start), 0);
        reset = 1'b0;
        tick();
        check_val("first_frame_start", int'(frame_start), 1);

        // Two idle frames.
        push_expect();
        frame_q.push_back(0);
        frame_q.push_back(0);
        measure_frame(-1, '0);
        measure_frame(-1, '0);

        // All channels forced on at full scale: current frame keeps duty 0.
        tone_disable  = 3'b111;
        noise_disable = 3'b111;
        amplitude_a   = 5'h0F;
        amplitude_b   = 5'h0F;
        amplitude_c   = 5'h0F;
        push_expect();
        frame_q.push_back(0);
        frame_q.push_back(765);
        measure_frame(-1, '0);
        measure_frame(-1, '0);

        // Drop channel B at counter 500: this frame stays 765, next is 510.
        frame_q.push_back(765);
        frame_q.push_back(510);
        measure_frame(499, 5'h00);
        measure_frame(-1, '0);

        // Envelope sweep on channel A.
        amplitude_a = 5'h10;
        amplitude_b = 5'h00;
        amplitude_c = 5'h00;
        for (int e = 0; e < 16; e++) begin
            envelope = 4'(e);
            push_expect();
            tick();
        end

        // Tone toggle on A with noise ignored.
        amplitude_a   = 5'h08;
        tone_disable  = 3'b110;
        noise_disable = 3'b001;
        noise         = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tone[0] = k[0];
            push_expect();
            tick();
        end

        // Random mixes.
        for (int k = 0; k < 24; k++) begin
            tone          = 3'($urandom);
            noise         = 1'($urandom);
            tone_disable  = 3'($urandom);
            noise_disable = 3'($urandom);
            amplitude_a   = 5'($urandom);
            amplitude_b   = 5'($urandom);
            amplitude_c   = 5'($urandom);
            envelope      = 4'($urandom);
            push_expect();
            tick();
        end

        // Asynchronous reset mid-frame with pwm_out high.
        tone_disable  = 3'b111;
        noise_disable = 3'b111;
        amplitude_a   = 5'h0F;
        amplitude_b   = 5'h0F;
        amplitude_c   = 5'h0F;
        push_expect();
        tick();
        wait_frame_start();
        tick();
        wait_frame_start();
        repeat (299) tick();
        check_val("counter_before_reset", int'(dut.counter), 300);
        check_val("pwm_before_reset", int'(pwm_out), 1);
        #1;
        reset = 1'b1;
        #1;
        check_val("async_pwm_out", int'(pwm_out), 0);
        check_val("async_mix_out", int'(mix_out), 0);
        check_val("async_counter", int'(dut.counter), 0);
        tick();
        reset = 1'b0;
        tick();
        check_val("restart_frame_start", int'(frame_start), 1);
        check_val("restart_pwm_out", int'(pwm_out), 0);
        check_val("scoreboard_drained", mix_q.size() + frame_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/amplitude_mixer_pwm.md
Name: amplitude_mixer_pwm

Overview:
- Output stage of each PSG core. Sits directly downstream of the tone generators, the noise generator and the envelope generator.
- Each of the three channels:
  - gates its tone bit and the shared noise bit through the mixer-disable bits;
  - selects either a fixed 4-bit amplitude or the shared envelope value;
  - converts that level to linear through a fixed logarithmic table.
- The three linear levels are summed.
- The sum drives a frame-synchronous PWM DAC on the output pin.

Parameters:
- ENVELOPE_BITS, 4, width of the envelope value and of the fixed amplitude field.
- LEVEL_BITS, 8, width of each linear level produced by the log table.
- MIX_BITS, 10, width of the three-channel sum; also the PWM counter width (frame = 2^MIX_BITS clocks).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tone  input  3  tone generator outputs; bit0 = A, bit1 = B, bit2 = C.
- noise  input  1  noise generator output, shared by all channels.
- tone_disable  input  3  mixer register bits; 1 = tone ignored for that channel.
- noise_disable  input  3  mixer register bits; 1 = noise ignored for that channel.
- amplitude_a  input  5  bit4 = envelope mode; bits[3:0] = fixed level. Same layout for amplitude_b and amplitude_c.
- amplitude_b  input  5  as amplitude_a.
- amplitude_c  input  5  as amplitude_a.
- envelope  input  ENVELOPE_BITS  envelope generator output, shared.
- mix_out  output  MIX_BITS  registered three-channel linear sum.
- frame_start  output  1  one-clock pulse when the PWM counter is 0.
- pwm_out  output  1  registered PWM DAC bit.

Behaviour:
- Gate per channel n: on_n = (tone[n] | tone_disable[n]) & (noise | noise_disable[n]).
  - Both disables set → channel constantly on, so its level is output as DC.
- Level per channel:
  - sel_n = amplitude_n[4] ? envelope : amplitude_n[3:0].
  - lvl_n = on_n ? sel_n : 0.
- Log table (combinational, 16 entries, 8-bit) for index 0..15: 0, 2, 3, 4, 6, 8, 11, 16, 23, 32, 45, 64, 90, 128, 181, 255.
- Mix:
  - sum = lin_a + lin_b + lin_c, zero-extended to MIX_BITS. No saturation; maximum is 765, which fits in 10 bits.
  - mix_out registers sum every clock, so latency is 1 clock from any input change.
- PWM counter:
  - MIX_BITS wide; increments every clock.
  - Wraps 1023 → 0 with no terminal hold.
  - frame_start is registered and high in the cycle the counter equals 0.
- Duty register:
  - Loads mix_out on the clock where the counter wraps to 0; holds otherwise.
  - A mid-frame change of mix_out never alters the current frame (glitch-free update).
- pwm_out is registered: pwm_out <= (counter < duty).
  - duty = 0 → constantly 0.
  - duty = 765 → high for exactly 765 of every 1024 clocks.
  - pwm_out can never be high for a full frame.
- Latency, input change to PWM effect:
  - 1 clock to mix_out;
  - then up to one full frame before the duty load;
  - then 1 clock register delay on pwm_out.
- Reset (asynchronous, any time): counter = 0, duty = 0, mix_out = 0, pwm_out = 0, frame_start = 0.
  - After release, the first frame_start pulse occurs 1 clock later.
  - The first nonzero duty applies from the frame after the first wrap.
- Reset asserted mid-frame truncates that frame; there is no partial-frame resumption.
- envelope and tone are sampled through mix_out only. Inputs arriving within the same clock as the duty load are deferred to the next frame.

Test Plan:
- Reset held then released, all inputs 0 → mix_out = 0, pwm_out = 0 for 2 full frames; frame_start pulses every 1024 clocks.
- tone_disable = 7, noise_disable = 7, amplitude_a/b/c = 0x0F → mix_out = 765 after 1 clock; from the next frame pwm_out is high exactly 765 clocks per 1024.
- amplitude_a = 0x10, envelope stepped 0..15, other channels 0 → mix_out follows the table values 0, 2, …, 181, 255 with 1-clock latency.
- amplitude_a = 0x08, tone[0] toggled, noise_disable[0] = 1, tone_disable[0] = 0 → mix_out alternates 23 / 0 with tone[0].
- Change amplitude_b from 0x0F to 0x00 at counter = 500 → the current frame keeps the old duty; the next frame's high time drops by 255 clocks.
- Assert reset at counter = 300 with pwm_out high → pwm_out, mix_out and counter read 0 immediately, without waiting for a clock edge.
